// File: rtl/bsg_dramsim3_read_arbiter.sv
// Round-robin arbiter sharing one dramsim3 channel read port among several requesters,
// with an outstanding-read credit limit and in-order routing of returned data-valid pulses.
module bsg_dramsim3_read_arbiter #(
  parameter int unsigned num_req_p            = 4,
  parameter int unsigned channel_addr_width_p = 29,
  parameter int unsigned max_outstanding_p    = 8,
  localparam int unsigned lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1,
  localparam int unsigned lg_out_lp     = $clog2(max_outstanding_p + 1),
  localparam int unsigned lg_depth_lp   = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1
) (
  input  logic                                           clk_i,
  input  logic                                           reset_i,
  input  logic [num_req_p-1:0]                           v_i,
  input  logic [num_req_p*channel_addr_width_p-1:0]      ch_addr_i,
  output logic [num_req_p-1:0]                           yumi_o,
  output logic                                           dram_v_o,
  output logic [channel_addr_width_p-1:0]                dram_ch_addr_o,
  input  logic                                           dram_yumi_i,
  input  logic                                           dram_data_v_i,
  output logic [num_req_p-1:0]                           data_v_o,
  output logic [lg_out_lp-1:0]                           outstanding_o,
  output logic                                           error_o
);

  localparam logic [lg_out_lp-1:0]     MaxCnt  = lg_out_lp'(max_outstanding_p);
  localparam logic [lg_depth_lp-1:0]   LastPtr = lg_depth_lp'(max_outstanding_p - 1);
  localparam logic [lg_num_req_lp-1:0] LastReq = lg_num_req_lp'(num_req_p - 1);

  typedef enum logic {StUnlocked, StLocked} state_e;

  state_e                     state_q, state_d;
  logic [lg_num_req_lp-1:0]   rr_q, rr_d;
  logic [lg_num_req_lp-1:0]   lock_id_q, lock_id_d;
  logic [lg_out_lp-1:0]       count_q, count_d;
  logic                       error_q, error_d;
  logic [lg_depth_lp-1:0]     wr_ptr_q, wr_ptr_d;
  logic [lg_depth_lp-1:0]     rd_ptr_q, rd_ptr_d;
  logic [lg_num_req_lp-1:0]   id_mem_q [max_outstanding_p];
  logic [lg_num_req_lp-1:0]   id_mem_d [max_outstanding_p];

  logic [channel_addr_width_p-1:0] addr_arr [num_req_p];
  logic [lg_num_req_lp-1:0]   grant_id;
  logic [lg_num_req_lp-1:0]   head_id;
  logic                       credit_ok;
  logic                       accept;
  logic                       pop;
  logic                       resp_err;

  function automatic logic [lg_depth_lp-1:0] ptr_inc(input logic [lg_depth_lp-1:0] p);
    if (p == LastPtr) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin : unpack_addr
    for (int unsigned i = 0; i < num_req_p; i++) begin
      addr_arr[i] = ch_addr_i[i*channel_addr_width_p +: channel_addr_width_p];
    end
  end

  // A locked grant holds the offered requester until dramsim3 takes it, so the
  // address cannot change under a pending offer.
  always_comb begin : grant_sel
    int unsigned idx;
    logic        found;
    idx      = 0;
    found    = 1'b0;
    grant_id = '0;
    if (state_q == StLocked) begin
      grant_id = lock_id_q;
    end else begin
      for (int unsigned i = 0; i < num_req_p; i++) begin
        idx = (int'(rr_q) + i) % num_req_p;
        if (!found && v_i[lg_num_req_lp'(idx)]) begin
          found    = 1'b1;
          grant_id = lg_num_req_lp'(idx);
        end
      end
    end
  end

  // Credit uses the registered count only; a same-cycle return never frees a slot early.
  assign credit_ok      = (count_q < MaxCnt);
  assign dram_v_o       = ~reset_i & (|v_i) & credit_ok;
  assign dram_ch_addr_o = addr_arr[grant_id];
  assign accept         = dram_v_o & dram_yumi_i;
  assign head_id        = id_mem_q[rd_ptr_q];
  assign pop            = ~reset_i & dram_data_v_i & (count_q != '0);
  assign resp_err       = ~reset_i & dram_data_v_i & (count_q == '0);

  always_comb begin : req_outputs
    yumi_o   = '0;
    data_v_o = '0;
    for (int unsigned i = 0; i < num_req_p; i++) begin
      yumi_o[i]   = accept & (grant_id == lg_num_req_lp'(i));
      data_v_o[i] = pop & (head_id == lg_num_req_lp'(i));
    end
  end

  assign outstanding_o = reset_i ? '0 : count_q;
  assign error_o       = ~reset_i & error_q;

  always_comb begin : next_state
    state_d   = state_q;
    rr_d      = rr_q;
    lock_id_d = lock_id_q;
    if (accept) begin
      rr_d    = (grant_id == LastReq) ? '0 : grant_id + 1'b1;
      state_d = StUnlocked;
    end else if (dram_v_o) begin
      state_d   = StLocked;
      lock_id_d = grant_id;
    end
  end

  always_comb begin : fifo_next
    id_mem_d = id_mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    error_d  = error_q | resp_err;
    if (accept) begin
      id_mem_d[wr_ptr_q] = grant_id;
      wr_ptr_d           = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (accept && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !accept) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StUnlocked;
      rr_q      <= '0;
      lock_id_q <= '0;
      count_q   <= '0;
      error_q   <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      lock_id_q <= lock_id_d;
      count_q   <= count_d;
      error_q   <= error_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Id storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk_i) begin
    id_mem_q <= id_mem_d;
  end

endmodule
